// File: rtl/systolic_ctrl_pkg.sv
// Shared types and default geometry for the systolic-array controllers.
// Latency: n/a (types only). Backpressure: n/a.
// State encoding is fixed (IDLE=0 .. OUT=4) so later controllers can share it.
package systolic_ctrl_pkg;

    localparam int ARRAY_H_DEF = 8;
    localparam int ARRAY_W_DEF = 8;
    localparam int K_MAX_DEF   = 16;
    localparam int K_W_DEF     = 5;
    localparam int CNT_W_DEF   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_OUT     = 3'd4
    } ctrl_state_t;

    // A pass needs at least one activation row and must fit the buffer.
    function automatic logic cfg_k_ok(input int k, input int k_max);
        return (k >= 1) && (k <= k_max);
    endfunction

endpackage

// File: rtl/ctrl_counter.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count flag.
// Latency: count updates one cycle after en; tc is combinational on the count.
// Backpressure: none; the caller gates en.
module ctrl_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == term);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for one systolic-array pass: load K rows, skewed compute, drain, emit ARRAY_H rows.
// Latency: k load beats + (k+H-1) compute + (W+H-1) drain + H result beats; outputs registered.
// Backpressure: LOAD holds on in_valid low, OUT holds indefinitely on out_ready low.
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ARRAY_H = ARRAY_H_DEF,
    parameter int ARRAY_W = ARRAY_W_DEF,
    parameter int K_MAX   = K_MAX_DEF,
    parameter int K_W     = K_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_W-1:0]             cfg_k,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       input_buffer_load_en,
    output logic [K_W-1:0]             load_addr,
    output logic                       input_buffer_out_en,
    output logic [CNT_W-1:0]           rd_addr,
    output logic                       acc_clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(ARRAY_H)-1:0] out_row_idx
);

    localparam int ROW_W = $clog2(ARRAY_H);
    localparam logic [CNT_W-1:0] DRAIN_TERM = CNT_W'(ARRAY_W + ARRAY_H - 2);
    localparam logic [ROW_W-1:0] ROW_TERM   = ROW_W'(ARRAY_H - 1);

    ctrl_state_t state, state_nxt;

    logic [K_W-1:0]   k_q;
    logic             start_ok;
    logic             out_acc;

    logic             load_clr, load_tc;
    logic [CNT_W-1:0] phase_cnt, phase_term;
    logic             phase_clr, phase_tc;
    logic             row_clr, row_tc;

    logic             busy_nxt, done_nxt, err_nxt, in_ready_nxt;
    logic             out_en_nxt, acc_clear_nxt, out_valid_nxt;
    logic [CNT_W-1:0] rd_addr_nxt;

    assign start_ok             = cfg_k_ok(int'(cfg_k), K_MAX);
    assign input_buffer_load_en = in_valid & in_ready;
    assign out_acc              = out_valid & out_ready;

    // Load counter doubles as the buffer write address; it returns to 0 once k rows are in.
    assign load_clr = (state != ST_LOAD) | (input_buffer_load_en & load_tc);

    ctrl_counter #(.W(K_W)) u_load_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (load_clr),
        .en   (input_buffer_load_en),
        .term (k_q - K_W'(1)),
        .cnt  (load_addr),
        .tc   (load_tc)
    );

    // One counter times both COMPUTE (k+H-1 cycles) and DRAIN (W+H-1 cycles).
    assign phase_term = (state == ST_COMPUTE) ? (CNT_W'(k_q) + CNT_W'(ARRAY_H - 2)) : DRAIN_TERM;
    assign phase_clr  = ((state != ST_COMPUTE) && (state != ST_DRAIN)) | phase_tc;

    ctrl_counter #(.W(CNT_W)) u_phase_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (phase_clr),
        .en   (1'b1),
        .term (phase_term),
        .cnt  (phase_cnt),
        .tc   (phase_tc)
    );

    assign row_clr = (state != ST_OUT) | (out_acc & row_tc);

    ctrl_counter #(.W(ROW_W)) u_row_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (row_clr),
        .en   (out_acc),
        .term (ROW_TERM),
        .cnt  (out_row_idx),
        .tc   (row_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start && start_ok)                  state_nxt = ST_LOAD;
            ST_LOAD:    if (input_buffer_load_en && load_tc)    state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (phase_tc)                           state_nxt = ST_DRAIN;
            ST_DRAIN:   if (phase_tc)                           state_nxt = ST_OUT;
            ST_OUT:     if (out_acc && row_tc)                  state_nxt = ST_IDLE;
            default:                                            state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the transition being taken.
    always_comb begin
        busy_nxt      = (state_nxt != ST_IDLE);
        in_ready_nxt  = (state_nxt == ST_LOAD);
        out_en_nxt    = (state_nxt == ST_COMPUTE);
        acc_clear_nxt = (state_nxt == ST_COMPUTE) && (state != ST_COMPUTE);
        out_valid_nxt = (state_nxt == ST_OUT);
        done_nxt      = (state == ST_OUT) && (state_nxt == ST_IDLE);
        err_nxt       = (state == ST_IDLE) && start && !start_ok;
        rd_addr_nxt   = '0;
        if ((state_nxt == ST_COMPUTE) && (state == ST_COMPUTE)) begin
            rd_addr_nxt = phase_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            k_q                 <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            in_ready            <= 1'b0;
            input_buffer_out_en <= 1'b0;
            rd_addr             <= '0;
            acc_clear           <= 1'b0;
            out_valid           <= 1'b0;
        end else begin
            state               <= state_nxt;
            if ((state == ST_IDLE) && start && start_ok) begin
                k_q <= cfg_k;
            end
            busy                <= busy_nxt;
            done                <= done_nxt;
            err                 <= err_nxt;
            in_ready            <= in_ready_nxt;
            input_buffer_out_en <= out_en_nxt;
            rd_addr             <= rd_addr_nxt;
            acc_clear           <= acc_clear_nxt;
            out_valid           <= out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with ARRAY_H=W=8, K_MAX=16; phase lengths hand-computed.
module tb_systolic_ctrl;

    localparam int AH = 8;
    localparam int AW = 8;
    localparam int KM = 16;
    localparam int KW = 5;
    localparam int CW = 6;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          busy, done, err;
    logic          in_valid, in_ready, input_buffer_load_en;
    logic [KW-1:0] load_addr;
    logic          input_buffer_out_en;
    logic [CW-1:0] rd_addr;
    logic          acc_clear;
    logic          out_valid, out_ready;
    logic [RW-1:0] out_row_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_ctrl #(
        .ARRAY_H (AH),
        .ARRAY_W (AW),
        .K_MAX   (KM),
        .K_W     (KW),
        .CNT_W   (CW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .cfg_k                (cfg_k),
        .busy                 (busy),
        .done                 (done),
        .err                  (err),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .input_buffer_load_en (input_buffer_load_en),
        .load_addr            (load_addr),
        .input_buffer_out_en  (input_buffer_out_en),
        .rd_addr              (rd_addr),
        .acc_clear            (acc_clear),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_row_idx          (out_row_idx)
    );

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_idle(input string name);
        check({name, ":busy"},      int'(busy), 0);
        check({name, ":done"},      int'(done), 0);
        check({name, ":err"},       int'(err), 0);
        check({name, ":in_ready"},  int'(in_ready), 0);
        check({name, ":load_en"},   int'(input_buffer_load_en), 0);
        check({name, ":load_addr"}, int'(load_addr), 0);
        check({name, ":out_en"},    int'(input_buffer_out_en), 0);
        check({name, ":rd_addr"},   int'(rd_addr), 0);
        check({name, ":acc_clear"}, int'(acc_clear), 0);
        check({name, ":out_valid"}, int'(out_valid), 0);
        check({name, ":row_idx"},   int'(out_row_idx), 0);
    endtask

    // Called at a sample point; that cycle is c0, the one in which start is presented.
    task automatic do_pass(input string name, input int k, input bit gappy, input bit hold_start,
                           input int stall_row, input int stall_n,
                           input int exp_load, input int exp_comp, input int exp_drain,
                           input int exp_out, input int exp_done);
        int cyc = 0;
        int first_load = -1;
        int n_load = 0, n_comp = 0, n_drain = 0, n_out = 0, n_clr = 0, n_err = 0;
        int n_loaded = 0, done_cyc = -1, exp_row = 0, stalled = 0, busy_at_done = 1;
        start     = 1'b1;
        cfg_k     = KW'(k);
        in_valid  = gappy ? 1'b0 : 1'b1;
        out_ready = 1'b1;
        while (done_cyc < 0 && cyc < 400) begin
            step();
            cyc++;
            if (done) begin
                done_cyc     = cyc;
                busy_at_done = int'(busy);
            end
            if (err)       n_err++;
            if (acc_clear) n_clr++;
            if (in_ready) begin
                n_load++;
                if (first_load < 0) first_load = cyc;
            end
            if (input_buffer_out_en) begin
                check({name, ":rd_addr"}, int'(rd_addr), n_comp);
                check({name, ":acc_clear"}, int'(acc_clear), (n_comp == 0) ? 1 : 0);
                n_comp++;
            end
            if (busy && !in_ready && !input_buffer_out_en && !out_valid) n_drain++;
            if (out_valid) begin
                check({name, ":row_idx"}, int'(out_row_idx), exp_row);
                n_out++;
            end
            start     = hold_start;
            in_valid  = gappy ? (cyc % 2 == 0) : 1'b1;
            out_ready = !(out_valid && int'(out_row_idx) == stall_row && stalled < stall_n);
            if (!out_ready) stalled++;
            if (out_valid && out_ready) exp_row++;
            #1;
            if (input_buffer_load_en) begin
                check({name, ":load_addr"}, int'(load_addr), n_loaded);
                n_loaded++;
            end
        end
        check({name, ":first_load"},   first_load, 1);
        check({name, ":load_cycles"},  n_load, exp_load);
        check({name, ":rows_loaded"},  n_loaded, k);
        check({name, ":comp_cycles"},  n_comp, exp_comp);
        check({name, ":acc_clears"},   n_clr, 1);
        check({name, ":drain_cycles"}, n_drain, exp_drain);
        check({name, ":out_cycles"},   n_out, exp_out);
        check({name, ":done_cycle"},   done_cyc, exp_done);
        check({name, ":busy_at_done"}, busy_at_done, 0);
        check({name, ":err_pulses"},   n_err, 0);
    endtask

    task automatic bad_start(input string name, input int k);
        start = 1'b1;
        cfg_k = KW'(k);
        step();
        start = 1'b0;
        check({name, ":err"},      int'(err), 1);
        check({name, ":busy"},     int'(busy), 0);
        check({name, ":in_ready"}, int'(in_ready), 0);
        step();
        check({name, ":err_pulse"}, int'(err), 0);
        check({name, ":busy2"},     int'(busy), 0);
        check({name, ":in_ready2"}, int'(in_ready), 0);
    endtask

    initial begin
        int n_done;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_k     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        check_all_idle("reset");
        rst = 1'b0;
        step();

        // 1: straight pass, LOAD c1-8, COMPUTE c9-23, DRAIN c24-38, OUT c39-46, done c47
        do_pass("basic", 8, 1'b0, 1'b0, -1, 0, 8, 15, 15, 8, 47);
        step();
        step();

        // 2: in_valid every other cycle stretches LOAD to 16 cycles
        do_pass("gappy", 8, 1'b1, 1'b0, -1, 0, 16, 15, 15, 8, 55);
        step();

        // 3: out-of-range cfg_k is rejected
        bad_start("k0", 0);
        bad_start("k17", 17);

        // 4: 5 stall cycles on row 3 delay done by 5
        do_pass("stall", 8, 1'b0, 1'b0, 3, 5, 8, 15, 15, 13, 52);
        step();

        // 5: reset in the middle of COMPUTE aborts the pass silently
        start    = 1'b1;
        cfg_k    = KW'(8);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        check("abort:out_en_before", int'(input_buffer_out_en), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_idle("abort");
        n_done = 0;
        repeat (60) begin
            step();
            if (done || busy) n_done++;
        end
        check("abort:no_done_no_busy", n_done, 0);
        do_pass("k1", 1, 1'b0, 1'b0, -1, 0, 1, 8, 15, 8, 33);
        step();

        // 6: start held high; second pass starts the cycle after done and matches the first
        do_pass("hold1", 8, 1'b0, 1'b1, -1, 0, 8, 15, 15, 8, 47);
        do_pass("hold2", 8, 1'b0, 1'b1, -1, 0, 8, 15, 15, 8, 47);
        start = 1'b0;
        step();
        check("hold:idle_after", int'(busy), 0);
        check("hold:done_pulse", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
